// File: rtl/fpu_pkg.sv
// pa_fpu: shared types and IEEE-754 single-precision constants for the fpu
package pa_fpu;
   typedef enum logic [1:0] {
      op_add = 2'd0,
      op_sub = 2'd1
   } e_fpu_op;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      ALIGN  = 3'd2,
      ADD    = 3'd3,
      NORM   = 3'd4,
      ROUND  = 3'd5,
      DONE   = 3'd6
   } e_fpu_state;
   localparam int                 EXP_BIAS = 127;
   localparam logic signed [9:0] EXP_MAX  = 10'(2 * EXP_BIAS + 1);
   localparam logic [31:0]       NAN      = 32'h7FC0_0000;
   localparam logic [31:0]       POS_INF  = 32'h7F80_0000;
   localparam logic [31:0]       NEG_INF  = 32'hFF80_0000;
endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero count of a 28-bit value (28 when all zero)
module fpu_lzc (
   input  logic [27:0] value,
   output logic [4:0]  count
);
   // highest set bit wins because later iterations overwrite earlier ones
   always_comb begin
      count = 5'd28;
      for (int i = 0; i < 28; i++) if (value[i]) count = 5'(27 - i);
   end
endmodule

// File: rtl/fpu.sv
// fpu: multi-cycle single-precision add/subtract, one FSM stage per cycle
module fpu
   import pa_fpu::*;
(
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  e_fpu_op     operation,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   output logic [31:0] ieee_packet_out,
   output logic        cmd_end,
   output logic        busy
);
   e_fpu_state        state_q, state_d;
   e_fpu_op           op_q, op_d;
   logic              start_q, start_d;
   logic [31:0]       a_q, a_d, b_q, b_d, spec_val_q, spec_val_d, res_q, res_d;
   logic              spec_q, spec_d, sa_q, sa_d, sb_q, sb_d, zero_q, zero_d;
   logic [7:0]        ea_q, ea_d, eb_q, eb_d;
   logic [26:0]       ma_q, ma_d, mb_q, mb_d;
   logic [27:0]       sum_q, sum_d;
   logic signed [9:0] er_q, er_d;
   // unpack helpers: b with subtraction folded into its sign
   logic [31:0]       bx, u_val;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_ok, u_spec;
   assign bx     = {b_q[31] ^ (op_q == op_sub), b_q[30:0]};
   assign a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
   assign b_nan  = (&bx[30:23]) && (|bx[22:0]);
   assign a_inf  = (&a_q[30:23]) && !(|a_q[22:0]);
   assign b_inf  = (&bx[30:23]) && !(|bx[22:0]);
   assign a_zero = a_q[30:23] == 8'd0;
   assign b_zero = bx[30:23] == 8'd0;
   assign op_ok  = (op_q == op_add) || (op_q == op_sub);
   assign u_spec = !op_ok || a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
   assign u_val  = (!op_ok || a_nan || b_nan) ? NAN :
                   (a_inf && b_inf)           ? ((a_q[31] == bx[31]) ? a_q : NAN) :
                   a_inf                      ? a_q :
                   b_inf                      ? bx :
                   (a_zero && b_zero)         ? {a_q[31] & bx[31], 31'd0} :
                   a_zero                     ? bx : a_q;
   // align helpers: x is the larger-exponent operand, y is shifted right
   logic        swap, al_lost;
   logic [7:0]  al_diff;
   logic [4:0]  al_sh;
   logic [26:0] al_my, al_ys;
   assign swap    = eb_q > ea_q;
   assign al_diff = swap ? eb_q - ea_q : ea_q - eb_q;
   assign al_sh   = (al_diff > 8'd27) ? 5'd27 : al_diff[4:0];
   assign al_my   = swap ? ma_q : mb_q;
   assign al_ys   = al_my >> al_sh;
   assign al_lost = |(al_my & ~(27'h7FF_FFFF << al_sh));
   // add helpers: effective subtraction keeps the larger magnitude's sign
   logic        eff_sub, a_ge;
   assign eff_sub = sa_q ^ sb_q;
   assign a_ge    = ma_q >= mb_q;
   // normalise helpers
   logic [4:0]  lz;
   logic [26:0] nm;
   fpu_lzc u_lzc (.value(sum_q), .count(lz));
   assign nm = sum_q[27] ? {sum_q[27:2], sum_q[1] | sum_q[0]} : 27'(sum_q << (lz - 5'd1));
   // round helpers: nearest-even on guard/round/sticky below bit 3
   logic              rnd_up;
   logic [24:0]       m25;
   logic signed [9:0] rex;
   logic [31:0]       r_res;
   assign rnd_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
   assign m25    = {1'b0, sum_q[26:3]} + {24'd0, rnd_up};
   assign rex    = er_q + (m25[24] ? 10'sd1 : 10'sd0);
   assign r_res  = spec_q           ? spec_val_q :
                   zero_q           ? 32'd0 :
                   (rex >= EXP_MAX) ? (sa_q ? NEG_INF : POS_INF) :
                   (rex <= 10'sd0)  ? {sa_q, 31'd0} :
                   {sa_q, rex[7:0], m25[24] ? m25[23:1] : m25[22:0]};
   // next state and per-stage datapath register updates
   always_comb begin
      state_d    = state_q;
      start_d    = start;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      spec_d     = spec_q;
      spec_val_d = spec_val_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      ea_d       = ea_q;
      eb_d       = eb_q;
      ma_d       = ma_q;
      mb_d       = mb_q;
      sum_d      = sum_q;
      er_d       = er_q;
      zero_d     = zero_q;
      res_d      = res_q;
      case (state_q)
         IDLE: if (start && !start_q) begin
            state_d = UNPACK;
            op_d    = operation;
            a_d     = a_operand;
            b_d     = b_operand;
         end
         UNPACK: begin
            state_d    = ALIGN;
            spec_d     = u_spec;
            spec_val_d = u_val;
            sa_d       = a_q[31];
            sb_d       = bx[31];
            ea_d       = a_q[30:23];
            eb_d       = bx[30:23];
            ma_d       = {1'b1, a_q[22:0], 3'b000};
            mb_d       = {1'b1, bx[22:0], 3'b000};
         end
         ALIGN: begin
            state_d = ADD;
            sa_d    = swap ? sb_q : sa_q;
            sb_d    = swap ? sa_q : sb_q;
            ea_d    = swap ? eb_q : ea_q;
            ma_d    = swap ? mb_q : ma_q;
            mb_d    = {al_ys[26:1], al_ys[0] | al_lost};
         end
         ADD: begin
            state_d = NORM;
            sum_d   = !eff_sub ? {1'b0, ma_q} + {1'b0, mb_q} :
                      a_ge     ? {1'b0, ma_q - mb_q} : {1'b0, mb_q - ma_q};
            sa_d    = (!eff_sub || a_ge) ? sa_q : sb_q;
            er_d    = $signed({2'b00, ea_q});
         end
         NORM: begin
            state_d = ROUND;
            zero_d  = sum_q == 28'd0;
            sum_d   = {1'b0, nm};
            er_d    = sum_q[27] ? er_q + 10'sd1 : er_q - $signed({5'd0, lz - 5'd1});
         end
         ROUND: begin
            state_d = DONE;
            res_d   = r_res;
         end
         default: state_d = IDLE;
      endcase
   end
   // state register; reset aborts any operation in flight
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         op_q       <= op_add;
         a_q        <= '0;
         b_q        <= '0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         ea_q       <= '0;
         eb_q       <= '0;
         ma_q       <= '0;
         mb_q       <= '0;
         sum_q      <= '0;
         er_q       <= '0;
         zero_q     <= 1'b0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         spec_q     <= spec_d;
         spec_val_q <= spec_val_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         ea_q       <= ea_d;
         eb_q       <= eb_d;
         ma_q       <= ma_d;
         mb_q       <= mb_d;
         sum_q      <= sum_d;
         er_q       <= er_d;
         zero_q     <= zero_d;
         res_q      <= res_d;
      end
   end
   assign ieee_packet_out = res_q;
   assign busy            = state_q != IDLE;
   assign cmd_end         = state_q == DONE;
endmodule

// File: tb/tb_fpu.sv
// tb_fpu: scoreboard bench for the fpu add/subtract unit
module tb_fpu;
   import pa_fpu::*;
   logic        clk = 1'b0, arst = 1'b0, start = 1'b0;
   e_fpu_op     operation = op_add;
   logic [31:0] a_operand = '0, b_operand = '0;
   logic [31:0] ieee_packet_out;
   logic        cmd_end, busy;
   int          n_chk = 0, n_pass = 0, cyc = 0;
   int          ends, busies, first_busy;
   logic [31:0] exp_q[$];
   int          end_q[$];
   string       tag_q[$];
   logic [31:0] exp_v;
   int          end_v;
   string       tag_v;

   fpu dut (
      .clk(clk), .arst(arst), .start(start), .operation(operation),
      .a_operand(a_operand), .b_operand(b_operand),
      .ieee_packet_out(ieee_packet_out), .cmd_end(cmd_end), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, want);
   endtask

   // compare each completed result against the oldest queued expectation
   always @(negedge clk) if (cmd_end) begin
      check("cmd_end_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         end_v = end_q.pop_front();
         tag_v = tag_q.pop_front();
         check({"result ", tag_v}, ieee_packet_out, exp_v);
         check({"latency ", tag_v}, 32'(cyc), 32'(end_v));
      end
   end

   task automatic push(input e_fpu_op op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
      operation = op;
      a_operand = a;
      b_operand = b;
      start     = 1'b1;
      exp_q.push_back(want);
      end_q.push_back(cyc + 6);
      tag_q.push_back($sformatf("%h op%0d %h", a, op, b));
   endtask

   task automatic run(input e_fpu_op op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
      @(posedge clk); #1;
      push(op, a, b, want);
      @(posedge clk); #1;
      start     = 1'b0;
      operation = e_fpu_op'(2'($urandom_range(0, 3)));
      a_operand = $urandom();
      b_operand = $urandom();
      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      end_q.delete();
      tag_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset_out", ieee_packet_out, 32'd0);
      check("reset_cmd_end", {31'd0, cmd_end}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      arst = 1'b1;
      run(op_add, 32'h3F80_0000, 32'h3F8C_CCCD, 32'h4006_6666);
      run(op_add, 32'h4180_0000, 32'h4200_0000, 32'h4240_0000);
      run(op_add, 32'h3E80_0000, 32'h3F00_0000, 32'h3F40_0000);
      run(op_add, 32'h4216_8F5C, 32'h0000_0000, 32'h4216_8F5C);
      run(op_add, 32'hFF80_0000, 32'h4120_0000, 32'hFF80_0000);
      run(op_add, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
      run(op_add, 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
      run(op_add, 32'h7FC0_0000, 32'h402D_F854, 32'h7FC0_0000);
      run(op_add, 32'h402D_F854, 32'h7FC0_0000, 32'h7FC0_0000);
      run(op_sub, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000);
      run(op_add, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
      run(op_add, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      run(op_sub, 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000);
      run(op_add, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000);
      run(op_add, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
      run(op_add, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
      run(op_add, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
      run(op_add, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
      run(op_sub, 32'h0000_0000, 32'h4120_0000, 32'hC120_0000);
      run(e_fpu_op'(2'd3), 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000);
      // start held high: one launch only
      @(posedge clk); #1;
      push(op_add, 32'h4180_0000, 32'h4200_0000, 32'h4240_0000);
      ends = 0;
      busies = 0;
      first_busy = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_end) ends++;
         if (busy) begin
            busies++;
            if (first_busy < 0) first_busy = i;
         end
      end
      start = 1'b0;
      check("hold_cmd_end_count", 32'(ends), 32'd1);
      check("hold_busy_cycles", 32'(busies), 32'd6);
      check("hold_busy_first", 32'(first_busy), 32'd1);
      check("hold_drain", 32'(exp_q.size()), 32'd0);
      // reset at cycle 3 aborts the operation
      @(posedge clk); #1;
      operation = op_add;
      a_operand = 32'h3F80_0000;
      b_operand = 32'h3F8C_CCCD;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      arst = 1'b0;
      @(negedge clk);
      check("abort_out", ieee_packet_out, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_cmd_end", {31'd0, cmd_end}, 32'd0);
      @(posedge clk); #1;
      arst = 1'b1;
      ends = 0;
      repeat (12) begin
         @(negedge clk);
         if (cmd_end) ends++;
      end
      check("abort_no_cmd_end", 32'(ends), 32'd0);
      check("abort_idle_busy", {31'd0, busy}, 32'd0);
      run(op_add, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
